// File: rtl/iiitb_wm_timer.sv
// Per-phase countdown timer that produces cycle_timeout/spin_timeout for automatic_washing_machine.
// Optional pause freeze is compiled in when WM_TIMER_PAUSE_EN is defined.
module iiitb_wm_timer #(
  parameter int PRESCALE  = 10,
  parameter int WASH_SEC  = 30,
  parameter int RINSE_SEC = 20,
  parameter int SPIN_SEC  = 15,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             motor_on,
  input  logic             soap_wash,
  input  logic             water_wash,
  input  logic             drain_value_on,
  input  logic             pause,
  output logic             cycle_timeout,
  output logic             spin_timeout,
  output logic [CNT_W-1:0] remaining_sec,
  output logic [1:0]       phase
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WASH  = 2'd1,
    RINSE = 2'd2,
    SPIN  = 2'd3
  } phase_t;

  localparam int PW = $clog2(PRESCALE);

  // Zero-length durations are stretched to one second so a phase never expires on entry.
  localparam logic [CNT_W-1:0] WASH_N  = CNT_W'((WASH_SEC  < 1) ? 1 : WASH_SEC);
  localparam logic [CNT_W-1:0] RINSE_N = CNT_W'((RINSE_SEC < 1) ? 1 : RINSE_SEC);
  localparam logic [CNT_W-1:0] SPIN_N  = CNT_W'((SPIN_SEC  < 1) ? 1 : SPIN_SEC);
  localparam logic [PW-1:0]    PRE_MAX = PW'(PRESCALE - 1);

  phase_t           state;
  phase_t           dphase;
  logic [PW-1:0]    presc;
  logic             frozen;
  logic             load;
  logic             run;
  logic             tick;
  logic             expire;
  logic [CNT_W-1:0] load_val;

`ifdef WM_TIMER_PAUSE_EN
  assign frozen = pause;
`else
  logic unused_pause;
  assign unused_pause = pause;
  assign frozen       = 1'b0;
`endif

  // State register: the registered phase simply follows the decoded phase.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= dphase;
  end

  // Next-state decode, drain has priority over soap over water.
  always_comb begin
    dphase = IDLE;
    if (motor_on && drain_value_on)  dphase = SPIN;
    else if (motor_on && soap_wash)  dphase = WASH;
    else if (motor_on && water_wash) dphase = RINSE;
  end

  // Output/control decode for the countdown datapath.
  always_comb begin
    load     = (dphase != state);
    load_val = '0;
    case (dphase)
      WASH:    load_val = WASH_N;
      RINSE:   load_val = RINSE_N;
      SPIN:    load_val = SPIN_N;
      default: load_val = '0;
    endcase
    run    = (state != IDLE) && (remaining_sec != '0) && !frozen;
    tick   = run && (presc == PRE_MAX);
    expire = tick && (remaining_sec == CNT_W'(1));
  end

  // A phase change reloads on the same edge and overrides any coincident tick or pause.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc         <= '0;
      remaining_sec <= '0;
      cycle_timeout <= 1'b0;
      spin_timeout  <= 1'b0;
    end else if (load) begin
      presc         <= '0;
      remaining_sec <= load_val;
      cycle_timeout <= 1'b0;
      spin_timeout  <= 1'b0;
    end else if (run) begin
      if (tick) begin
        presc         <= '0;
        remaining_sec <= remaining_sec - CNT_W'(1);
      end else begin
        presc <= presc + PW'(1);
      end
      if (expire) begin
        if (state == SPIN) spin_timeout  <= 1'b1;
        else               cycle_timeout <= 1'b1;
      end
    end
  end

  assign phase = state;

endmodule

// File: tb/tb_iiitb_wm_timer.sv
// Self-checking bench for iiitb_wm_timer: directed test-plan scenarios plus randomized phase sequences
// compared every cycle against an elapsed-time model.
module tb_iiitb_wm_timer;

  localparam int P  = 4;
  localparam int WS = 3;
  localparam int RS = 2;
  localparam int SS = 2;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          motor_on = 1'b0;
  logic          soap_wash = 1'b0;
  logic          water_wash = 1'b0;
  logic          drain_value_on = 1'b0;
  logic          pause = 1'b0;
  logic          cycle_timeout;
  logic          spin_timeout;
  logic [CW-1:0] remaining_sec;
  logic [1:0]    phase;

  iiitb_wm_timer #(
    .PRESCALE (P),
    .WASH_SEC (WS),
    .RINSE_SEC(RS),
    .SPIN_SEC (SS),
    .CNT_W    (CW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .motor_on      (motor_on),
    .soap_wash     (soap_wash),
    .water_wash    (water_wash),
    .drain_value_on(drain_value_on),
    .pause         (pause),
    .cycle_timeout (cycle_timeout),
    .spin_timeout  (spin_timeout),
    .remaining_sec (remaining_sec),
    .phase         (phase)
  );

  always #5 clk = ~clk;

`ifdef WM_TIMER_PAUSE_EN
  localparam bit PAUSE_ON = 1'b1;
`else
  localparam bit PAUSE_ON = 1'b0;
`endif

  int checks = 0;
  int passed = 0;

  // Model: current phase and the number of counting cycles spent in it.
  int m_phase = 0;
  int m_el    = 0;

  function automatic int dur_of(input int p);
    int d;
    case (p)
      1:       d = WS;
      2:       d = RS;
      3:       d = SS;
      default: d = 0;
    endcase
    if (p != 0 && d < 1) d = 1;
    return d;
  endfunction

  function automatic int decode(input logic m, input logic s, input logic w, input logic d);
    if (m && d) return 3;
    if (m && s) return 1;
    if (m && w) return 2;
    return 0;
  endfunction

  function automatic int m_rem();
    if (m_phase == 0) return 0;
    return dur_of(m_phase) - m_el / P;
  endfunction

  function automatic int m_cto();
    return ((m_phase == 1 || m_phase == 2) && m_el == dur_of(m_phase) * P) ? 1 : 0;
  endfunction

  function automatic int m_sto();
    return (m_phase == 3 && m_el == dur_of(m_phase) * P) ? 1 : 0;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
  endtask

  task automatic cmp_model();
    chk("phase", int'(phase), m_phase);
    chk("remaining_sec", int'(remaining_sec), m_rem());
    chk("cycle_timeout", int'(cycle_timeout), m_cto());
    chk("spin_timeout", int'(spin_timeout), m_sto());
  endtask

  // One clock: advance the model with the inputs seen at the edge, then compare.
  task automatic step();
    int dp;
    @(posedge clk);
    #1;
    if (reset) begin
      dp = decode(motor_on, soap_wash, water_wash, drain_value_on);
      if (dp != m_phase) begin
        m_phase = dp;
        m_el    = 0;
      end else if (m_phase != 0 && m_el < dur_of(m_phase) * P && !(PAUSE_ON && pause)) begin
        m_el++;
      end
    end
    cmp_model();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic set_in(input logic m, input logic s, input logic w, input logic d);
    motor_on       = m;
    soap_wash      = s;
    water_wash     = w;
    drain_value_on = d;
  endtask

  task automatic async_reset_pulse();
    #2 reset = 1'b0;
    #1;
    m_phase = 0;
    m_el    = 0;
    chk("async_rst_phase", int'(phase), 0);
    chk("async_rst_rem", int'(remaining_sec), 0);
    chk("async_rst_cto", int'(cycle_timeout), 0);
    chk("async_rst_sto", int'(spin_timeout), 0);
    #1 reset = 1'b1;
  endtask

  initial begin
    // 1: reset held with WASH inputs, then release
    set_in(1, 1, 0, 0);
    steps(2);
    chk("rst_phase", int'(phase), 0);
    chk("rst_rem", int'(remaining_sec), 0);
    chk("rst_cto", int'(cycle_timeout), 0);
    reset = 1'b1;
    step();
    chk("entry_phase", int'(phase), 1);
    chk("entry_rem", int'(remaining_sec), 3);

    // 2: WASH countdown and expiry
    steps(4);
    chk("wash_rem_e4", int'(remaining_sec), 2);
    steps(4);
    chk("wash_rem_e8", int'(remaining_sec), 1);
    steps(3);
    chk("wash_cto_e11", int'(cycle_timeout), 0);
    step();
    chk("wash_rem_e12", int'(remaining_sec), 0);
    chk("wash_cto_e12", int'(cycle_timeout), 1);
    steps(3);
    chk("wash_cto_held", int'(cycle_timeout), 1);
    chk("wash_sto", int'(spin_timeout), 0);

    // 3: direct WASH -> RINSE
    set_in(1, 0, 1, 0);
    step();
    chk("rinse_cto_drop", int'(cycle_timeout), 0);
    chk("rinse_rem", int'(remaining_sec), 2);
    steps(7);
    chk("rinse_cto_e7", int'(cycle_timeout), 0);
    step();
    chk("rinse_cto_e8", int'(cycle_timeout), 1);

    // 4: SPIN has priority over soap
    set_in(1, 1, 0, 1);
    step();
    chk("spin_phase", int'(phase), 3);
    steps(7);
    chk("spin_sto_e7", int'(spin_timeout), 0);
    step();
    chk("spin_sto_e8", int'(spin_timeout), 1);
    chk("spin_cto", int'(cycle_timeout), 0);

    // 5: abort mid-WASH, re-entry, then async reset mid-count
    set_in(0, 0, 0, 0);
    step();
    set_in(1, 1, 0, 0);
    step();
    steps(5);
    set_in(0, 1, 0, 0);
    step();
    chk("abort_phase", int'(phase), 0);
    chk("abort_rem", int'(remaining_sec), 0);
    set_in(1, 1, 0, 0);
    step();
    chk("reentry_rem", int'(remaining_sec), 3);
    steps(11);
    chk("reentry_cto_e11", int'(cycle_timeout), 0);
    step();
    chk("reentry_cto_e12", int'(cycle_timeout), 1);
    set_in(0, 0, 0, 0);
    step();
    set_in(1, 1, 0, 0);
    steps(6);
    async_reset_pulse();
    step();
    chk("post_rst_rem", int'(remaining_sec), 3);

    // 6: pause for 5 cycles starting at E0+5
    set_in(0, 0, 0, 0);
    step();
    set_in(1, 1, 0, 0);
    step();
    steps(4);
    pause = 1'b1;
    steps(5);
    pause = 1'b0;
    steps(3);
    chk("pause_cto_e12", int'(cycle_timeout), PAUSE_ON ? 0 : 1);
    steps(4);
    chk("pause_cto_e16", int'(cycle_timeout), PAUSE_ON ? 0 : 1);
    step();
    chk("pause_cto_e17", int'(cycle_timeout), 1);

    // Randomized phase sequences with occasional pause and async reset
    for (int seg = 0; seg < 120; seg++) begin
      int hold;
      set_in(1'($urandom_range(0, 5) != 0), 1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0));
      hold = $urandom_range(1, 20);
      for (int c = 0; c < hold; c++) begin
        pause = 1'($urandom_range(0, 5) == 0);
        if ($urandom_range(0, 199) == 0) async_reset_pulse();
        step();
      end
    end
    pause = 1'b0;

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/iiitb_wm_timer.md
# iiitb_wm_timer

Phase timer that sits directly upstream of `automatic_washing_machine` and generates its `cycle_timeout` and `spin_timeout` inputs. It decodes the machine's current phase from its outputs (`motor_on`, `soap_wash`, `water_wash`, `drain_value_on`), loads a per-phase duration, and counts it down in seconds using a clock prescaler. It also exposes remaining time and decoded phase for a display stage.

## Interface

Parameters:
- `PRESCALE`, default 10: clock cycles per second tick. Must be ≥ 2.
- `WASH_SEC`, default 30: soap-wash duration in seconds.
- `RINSE_SEC`, default 20: water-wash (rinse) duration in seconds.
- `SPIN_SEC`, default 15: spin duration in seconds.
- `CNT_W`, default 8: width of the seconds counter. Must hold max(`WASH_SEC`, `RINSE_SEC`, `SPIN_SEC`).

Ports:
- `clk` input 1: system clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-low. 0 = reset asserted.
- `motor_on` input 1: from the washing machine.
- `soap_wash` input 1: from the washing machine.
- `water_wash` input 1: from the washing machine.
- `drain_value_on` input 1: from the washing machine.
- `pause` input 1: freeze request. Ignored unless `WM_TIMER_PAUSE_EN` is defined.
- `cycle_timeout` output 1: wash or rinse duration expired. Registered level.
- `spin_timeout` output 1: spin duration expired. Registered level.
- `remaining_sec` output `CNT_W`: seconds left in the current phase.
- `phase` output 2: registered phase. 0 = IDLE, 1 = WASH, 2 = RINSE, 3 = SPIN.

## Operation

Combinational phase decode (`dphase`), evaluated in priority order:
- SPIN if `motor_on & drain_value_on`.
- Otherwise WASH if `motor_on & soap_wash`.
- Otherwise RINSE if `motor_on & water_wash`.
- Otherwise IDLE.

State register `phase` uses states IDLE, WASH, RINSE, SPIN. On any edge where `dphase != phase`:
- `phase` ← `dphase`.
- `remaining_sec` ← the duration for `dphase` (0 for IDLE).
- Prescaler ← 0.
- `cycle_timeout` ← 0 and `spin_timeout` ← 0.

While `dphase == phase != IDLE` and `remaining_sec > 0`:
- The prescaler counts 0 to `PRESCALE-1` and wraps.
- The wrap cycle is the second tick; `remaining_sec` decrements on it.
- On the tick where `remaining_sec` goes 1 → 0:
  - If `phase` is WASH or RINSE, `cycle_timeout` ← 1.
  - If `phase` is SPIN, `spin_timeout` ← 1.

Once expired:
- The counter holds at 0 and the prescaler stops.
- The timeout output stays high until the phase changes.

In IDLE: `remaining_sec` = 0, prescaler = 0, both timeouts = 0.

Width rule: a duration parameter of 0 is treated as 1, so the timer never expires at entry.

## Timing

- Reset values: `cycle_timeout` = 0, `spin_timeout` = 0, `remaining_sec` = 0, `phase` = 0 (IDLE), prescaler = 0.
- Entry latency: `dphase` is sampled at edge E0; `phase` and `remaining_sec` update at E0.
- `remaining_sec` decrements at E0+k·`PRESCALE` for k = 1..N, where N is the phase duration.
- The timeout asserts at edge E0+N·`PRESCALE`, coincident with `remaining_sec` reaching 0.
- Direct phase-to-phase change (e.g. WASH→RINSE with no IDLE between): reload on the same edge. An old timeout drops on that edge.
- Abort mid-phase (→ IDLE): the count is discarded. Re-entry reloads the full duration.
- Reset asserted mid-count: all state clears immediately (asynchronously). After release, counting resumes only on the next edge where `dphase != phase`.
- Phase change on the same edge as the expiring tick: the phase change wins. Reload occurs and no timeout asserts.

## Configuration

Macro `WM_TIMER_PAUSE_EN`.
- Defined: while `pause` = 1 and `phase` ≠ IDLE:
  - Prescaler and `remaining_sec` freeze; no decrement and no timeout.
  - Phase-change reload still takes priority over `pause`.
  - Counting resumes from the frozen prescaler value on the first edge with `pause` = 0.
- Undefined: `pause` is unused and timing is exactly as described above.

## Test plan

All scenarios use `PRESCALE`=4, `WASH_SEC`=3, `RINSE_SEC`=2, `SPIN_SEC`=2.

1. Hold `reset`=0 for 2 cycles with WASH inputs active → all outputs 0, `phase`=0. Release → `phase`=1 and `remaining_sec`=3 at the first edge.
2. WASH entered at E0 → `remaining_sec` = 2, 1, 0 at E0+4, E0+8, E0+12. `cycle_timeout`=1 from E0+12 and held. `spin_timeout`=0 throughout.
3. After WASH expiry, switch `soap_wash`→0 and `water_wash`→1 at edge E1 → `cycle_timeout`=0 and `remaining_sec`=2 at E1. `cycle_timeout` reasserts at E1+8.
4. SPIN (`motor_on`=1, `drain_value_on`=1, `soap_wash`=1) entered at E2 → `phase`=3. `spin_timeout`=1 at E2+8. `cycle_timeout` stays 0.
5. Drop `motor_on` at E0+6 during WASH → IDLE, `remaining_sec`=0, no timeout. Re-entry at E3 → `cycle_timeout` at E3+12. Also: async reset at E0+6 clears everything without waiting for an edge.
6. With `WM_TIMER_PAUSE_EN` defined: `pause`=1 for 5 cycles starting at E0+5 during WASH → `cycle_timeout` at E0+17. Without the macro, the same stimulus gives E0+12.
